inst_fetch_unit: RTL and testbench

//  Instruction-fetch front end: consumer of the current-PC register.
//  - Owns fetch_pc, issues in-order read requests to instruction memory, buffers returned words in a small FIFO.
//  - Presents {pc, instruction} to decode over a valid/ready handshake.
//  - Redirect input (branch/jump/trap target from the PC/next-PC logic) flushes all in-flight and buffered fetches.

---
 rtl/ifetch_pkg.sv | 13 +
 rtl/inst_fetch_unit_fifo.sv | 61 ++++++
 rtl/inst_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_inst_fetch_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package ifetch_pkg;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Layout of one buffered fetch at the default 32-bit widths.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// Small synchronous FIFO with flush and occupancy count.
// The head entry is read straight from registered storage, and reset clears
// the storage so the head reads as zero.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  // Pointer, count and storage update; flush has priority over push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= ptr_inc(wptr);
      end
      if (do_pop) rptr <= ptr_inc(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: issues in-order word reads from fetch_pc,
// buffers returned words with their PCs, and hands them to decode.
// A redirect flushes the buffer and turns every outstanding response
// (including a request still waiting for grant) into a drop.
module inst_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [DATA_W-1:0] inst_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  logic [ADDR_W-1:0]        fetch_pc;
  logic [ADDR_W-1:0]        stale_addr;
  logic                     pending;
  logic                     stale;
  logic [CW-1:0]            inflight;
  logic [CW-1:0]            inflight_next;
  logic [CW-1:0]            drop;
  logic                     grant;
  logic                     resp;
  logic                     credit;
  logic [SW-1:0]            occupancy;

  logic                     fifo_push;
  logic                     fifo_pop;
  logic [CW-1:0]            fifo_count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [ADDR_W+DATA_W-1:0] fifo_rdata;

  logic [ADDR_W-1:0]        tag_pc;
  logic [CW-1:0]            tag_count;
  logic                     tag_full;
  logic                     tag_empty;

  // Every fetch either in flight or buffered holds one FIFO slot in reserve.
  assign occupancy = SW'(inflight) + SW'(fifo_count);
  assign credit    = occupancy < SW'(DEPTH);

  // A request once raised is held until granted, whatever happens meanwhile.
  assign mem_req  = !rst && (pending || credit);
  // A request left over from before a redirect keeps its original address.
  assign mem_addr = stale ? stale_addr : fetch_pc;

  assign grant         = mem_req && mem_gnt;
  assign resp          = mem_rvalid && (inflight != '0);
  assign inflight_next = inflight + CW'(grant) - CW'(resp);

  assign fifo_push = resp && (drop == '0);
  assign fifo_pop  = inst_valid && inst_ready;

  assign inst_valid         = !fifo_empty;
  assign {inst_pc, inst_data} = fifo_rdata;

  sync_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_inst_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (fifo_push),
    .wdata ({tag_pc, mem_rdata}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // PC tags follow requests in grant order; dropped responses still consume theirs.
  sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (grant),
    .wdata (mem_addr),
    .pop   (resp),
    .rdata (tag_pc),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  // Fetch address, request hold and in-flight/drop bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      stale_addr <= '0;
      pending    <= 1'b0;
      stale      <= 1'b0;
      inflight   <= '0;
      drop       <= '0;
    end else begin
      pending  <= mem_req && !mem_gnt;
      inflight <= inflight_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~ADDR_W'(INSTR_BYTES - 1);
        drop     <= inflight_next;
        if (mem_req && !mem_gnt) begin
          stale      <= 1'b1;
          stale_addr <= mem_addr;
        end else begin
          stale <= 1'b0;
        end
      end else begin
        if (grant && !stale) fetch_pc <= fetch_pc + ADDR_W'(INSTR_BYTES);
        if (grant) stale <= 1'b0;
        drop <= drop - CW'(resp && (drop != '0)) + CW'(grant && stale);
      end
    end
  end

  // Simulation-time protocol and bookkeeping checks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(mem_rvalid && (inflight == '0)))
        else $error("mem_rvalid with nothing in flight");
      assert (occupancy <= SW'(DEPTH))
        else $error("in-flight plus buffered fetches exceed DEPTH");
      assert (tag_count == inflight)
        else $error("PC tag queue out of step with in-flight count");
      assert (!(resp && tag_empty))
        else $error("response without a PC tag");
      assert (!(grant && tag_full && !resp))
        else $error("PC tag queue overflow");
      assert (!(fifo_push && fifo_full && !fifo_pop && !redirect_valid))
        else $error("instruction FIFO overflow");
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus a random
// soak, all compared against a transaction-level model of the fetch front end.
module tb_inst_fetch_unit;
  import ifetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data)
  );

  typedef struct {
    logic [31:0] addr;
    bit          kill;
  } req_t;

  // Reference model: outstanding requests in order, and what decode should see.
  req_t         outst[$];
  fetch_entry_t expq[$];
  bit           held;
  bit           held_kill;
  logic [31:0]  held_addr;
  logic [31:0]  nxt_pc;
  bit           prev_rst;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit r, input bit gnt, input bit rv, input bit rdy,
                       input bit rd, input logic [31:0] rd_pc);
    bit          exp_req;
    bit          grant;
    bit          rvv;
    logic [31:0] exp_addr;
    logic [31:0] rdat;
    req_t        e;
    rvv            = rv && (r || (outst.size() > 0));
    rdat           = $urandom;
    rst            = r;
    mem_gnt        = gnt;
    mem_rvalid     = rvv;
    mem_rdata      = rdat;
    inst_ready     = rdy;
    redirect_valid = rd;
    redirect_pc    = rd_pc;
    #1;
    exp_req  = !r && (held || ((outst.size() + expq.size()) < DEPTH));
    exp_addr = held ? held_addr : nxt_pc;
    check("mem_req", 32'(mem_req), 32'(exp_req));
    if (exp_req) check("mem_addr", mem_addr, exp_addr);
    check("inst_valid", 32'(inst_valid), 32'(expq.size() != 0));
    if (expq.size() != 0) begin
      check("inst_pc", inst_pc, expq[0].pc);
      check("inst_data", inst_data, expq[0].data);
    end else if (prev_rst) begin
      check("rst_inst_pc", inst_pc, 32'h0);
      check("rst_inst_data", inst_data, 32'h0);
    end
    if (r) begin
      outst.delete();
      expq.delete();
      held      = 1'b0;
      held_kill = 1'b0;
      nxt_pc    = 32'h0;
    end else begin
      grant = exp_req && gnt;
      if ((expq.size() != 0) && rdy) void'(expq.pop_front());
      if (rvv) begin
        e = outst.pop_front();
        if (!e.kill && !rd) expq.push_back('{pc: e.addr, data: rdat});
      end
      if (grant) begin
        outst.push_back('{addr: exp_addr, kill: held_kill});
        if (!held_kill) nxt_pc = exp_addr + 32'd4;
        held      = 1'b0;
        held_kill = 1'b0;
      end else if (exp_req) begin
        held      = 1'b1;
        held_addr = exp_addr;
      end
      if (rd) begin
        foreach (outst[i]) outst[i].kill = 1'b1;
        expq.delete();
        nxt_pc = rd_pc & ~32'h3;
        if (held) held_kill = 1'b1;
      end
    end
    prev_rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int gp, input int rp, input int yp, input int dp);
    for (int i = 0; i < n; i++)
      cycle(1'b0, $urandom_range(99) < gp, $urandom_range(99) < rp,
            $urandom_range(99) < yp, $urandom_range(99) < dp, $urandom);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b1, $urandom_range(1) == 1, $urandom_range(1) == 1, 1'b1, $urandom_range(1) == 1, $urandom);
  endtask

  initial begin
    rst            = 1'b1;
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    held           = 1'b0;
    held_kill      = 1'b0;
    held_addr      = '0;
    nxt_pc         = '0;
    prev_rst       = 1'b1;
    @(posedge clk);
    #1;

    // Streaming fetch with immediate grant and one-cycle responses.
    do_reset(3);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("t1_first_valid", 32'(inst_valid), 32'h1);
    check("t1_first_pc", inst_pc, 32'h0);
    run(20, 100, 100, 100, 0);

    // Decode stalls: buffer fills to DEPTH and the head holds.
    do_reset(2);
    run(10, 100, 100, 0, 0);
    check("t2_hold_pc", inst_pc, 32'h0);
    run(15, 100, 100, 100, 0);

    // Ungranted request survives a redirect and its data is dropped.
    do_reset(2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0101);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("t3_addr_held", mem_addr, 32'h0);
    run(15, 100, 100, 100, 0);

    // Redirect coinciding with a response while two are in flight.
    do_reset(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
    run(15, 100, 100, 100, 0);

    // Address wrap at the top of the address space.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    run(15, 100, 100, 100, 0);

    // Reset in the middle of traffic, with stale responses during reset.
    run(8, 100, 50, 0, 0);
    do_reset(3);
    check("t6_req_low", 32'(mem_req), 32'h0);
    run(15, 100, 100, 100, 0);

    // Random soak.
    run(3000, 60, 50, 60, 5);
    run(500, 90, 90, 90, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
